fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous `fifo` write port between `NUM_REQ` producers. Each producer offers data on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` beats and drives the FIFO's `wr`/`data_in` pins. It honours `full` so that no write is ever lost or dropped, and sits directly in front of the FIFO `wr`/`data_in` inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `DATA_W`, default 8: data width; must match FIFO `data_in`.
- `MAX_BURST`, default 4: maximum accepted beats per grant, minimum 1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester data valid.
- `req_data`  in  `NUM_REQ*DATA_W`  packed data; requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wr`  out  1  to FIFO `wr`.
- `fifo_data`  out  `DATA_W`  to FIFO `data_in`.
- `grant_id`  out  `$clog2(NUM_REQ)`  current/last owner index.
- `busy`  out  1  high while in BURST.

## Operation
- States: `ARB_IDLE`, `ARB_BURST`.
- Registers:
  - `state`
  - `owner` (drives `grant_id`)
  - `rr_ptr`, the highest-priority index for the next arbitration
  - `beat_cnt`, width `$clog2(MAX_BURST+1)`
- **`ARB_IDLE`:**
  - No grant is active. `req_ready`=0 and `fifo_wr`=0.
  - If any `req_valid` is high, pick the first valid index scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
  - Load `owner` with that index, clear `beat_cnt`, and go to `ARB_BURST`.
- **`ARB_BURST`:**
  - `req_ready[owner] = !fifo_full`.
  - `fifo_wr = req_valid[owner] && !fifo_full`.
  - `fifo_data = req_data[owner]`.
  - A beat occurs when `fifo_wr`=1; on a beat, `beat_cnt` increments.
- **Release**, i.e. go to `ARB_IDLE` with `rr_ptr <= owner+1` (wraps from `NUM_REQ-1` to 0):
  - (a) a beat occurs with `beat_cnt == MAX_BURST-1`, or
  - (b) `req_valid[owner]`=0 at a clock edge.
- `fifo_full` high in BURST:
  - No write, no beat, `beat_cnt` frozen, grant held.
  - There is no timeout.
- `fifo_data` is 0 whenever `state == ARB_IDLE`.
- Requests from non-owners are ignored during BURST. Their `req_ready` stays 0.

## Timing
- Reset, with `rst`=0 sampled at a rising edge, gives on the next cycle:
  - `state`=IDLE, `owner`=0, `rr_ptr`=0, `beat_cnt`=0.
  - Outputs: `req_ready`=0, `fifo_wr`=0, `fifo_data`=0, `grant_id`=0, `busy`=0.
- Reset mid-burst aborts the burst. No write occurs in the reset cycle's successor.
- Request-to-first-write latency is 1 cycle. A valid seen in IDLE at edge N produces `fifo_wr` during cycle N+1, provided not full.
- Between consecutive bursts there is exactly one IDLE bubble cycle.
- Sustained throughput with all requesters valid is `MAX_BURST/(MAX_BURST+1)` beats per cycle.
- `fifo_wr`, `fifo_data` and `req_ready` are combinational from registered state plus `req_valid`/`fifo_full`. There is no combinational path from `req_data` to any control output.
- The FIFO samples `wr`/`data_in` at the same edge where the requester observes `valid && ready`.

## Structure
- Package `fifo_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t`.
  - Localparam helper for the index width.
- Sub-module `rr_picker`, purely combinational:
  - Inputs `req[NUM_REQ]` and `start`.
  - Outputs `any` and `idx`, the first set bit at or after `start` with wrap-around.
- Top level holds the FSM, counters and output muxing.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `req_valid`=4'b1111 -> all outputs at reset values; after release, first grant is `grant_id`=0.
- **Single requester:** requester 1 offers 8'hAA then 8'h55 with valid held for 2 beats, then dropped.
  - Required: one IDLE cycle; then `fifo_wr`=1 for 2 cycles with `fifo_data` AA, 55; `grant_id`=1.
  - Then release back to IDLE; the next arbitration starts at index 2.
- **Full contention:** all four requesters valid continuously, `MAX_BURST`=4.
  - Required: grants run 0, 1, 2, 3, 0, each exactly 4 beats.
  - One bubble between bursts; 20 writes in 25 cycles.
- **Backpressure:** `fifo_full`=1 for 3 cycles after beat 2 of requester 0.
  - Required: `fifo_wr`=0 and `req_ready`=0 for those cycles; grant held.
  - Then 2 more beats, giving 4 total; no data lost or duplicated.
- **Early release:** requester 2 drops valid after 1 beat while requester 3 is valid -> after one IDLE cycle, `grant_id`=3.
- **Reset mid-burst:** `rst`=0 during beat 2 -> next cycle IDLE with `rr_ptr`=0 and no write; arbitration restarts at requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Used by the round-robin picker and the arbiter top level.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_BURST
   } arb_state_t;

   // Index width, never below one bit so ports stay legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MAX_BURST = 4;
   localparam int DEF_IDX_W     = idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after
// start, wrapping modulo NUM_REQ.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int IW     = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      start,
   output logic               any,
   output logic [IW-1:0]      idx
);

   logic [IW:0] pos;

   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, start} + (IW+1)'(k);
         if (pos >= (IW+1)'(NUM_REQ)) begin
            pos = pos - (IW+1)'(NUM_REQ);
         end
         if (!any && req[pos[IW-1:0]]) begin
            any = 1'b1;
            idx = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ
// producers, granting bursts of up to MAX_BURST beats.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST,
   localparam int IW       = idx_w(NUM_REQ),
   localparam int BW       = $clog2(MAX_BURST + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr,
   output logic [DATA_W-1:0]         fifo_data,
   output logic [IW-1:0]             grant_id,
   output logic                      busy
);

   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

   arb_state_t    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;

   logic          pick_any;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] owner_nxt;
   logic          own_valid;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req   (req_valid),
      .start (rr_ptr_q),
      .any   (pick_any),
      .idx   (pick_idx)
   );

   assign own_valid = req_valid[owner_q];
   assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
   assign grant_id  = owner_q;
   assign busy      = (state_q == ARB_BURST);

   // Outputs depend on registered state plus valid/full only;
   // req_data reaches fifo_data alone.
   always_comb begin
      req_ready = '0;
      fifo_wr   = 1'b0;
      fifo_data = '0;
      if (state_q == ARB_BURST) begin
         req_ready[owner_q] = !fifo_full;
         fifo_wr            = own_valid && !fifo_full;
         fifo_data          = req_data[owner_q*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               owner_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = ARB_BURST;
            end
         end
         ARB_BURST: begin
            if (fifo_wr) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (!own_valid || (fifo_wr && beat_cnt_q == LAST_BEAT)) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = owner_nxt;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ARB_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with NUM_REQ=4, DATA_W=8,
// MAX_BURST=4.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr;
   logic [7:0]  fifo_data;
   logic [1:0]  grant_id;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int writes;
   int idles;

   fifo_wr_arbiter #(
      .NUM_REQ   (4),
      .DATA_W    (8),
      .MAX_BURST (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_full (fifo_full),
      .fifo_wr   (fifo_wr),
      .fifo_data (fifo_data),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req_valid = 4'b0000;
      fifo_full = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 4'b1111;
      req_data  = 32'h33_22_11_00;
      fifo_full = 1'b0;

      // reset held two cycles with all valid
      tick();
      tick();
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_wr", 32'(fifo_wr), 32'h0);
      chk("rst_data", 32'(fifo_data), 32'h0);
      chk("rst_gid", 32'(grant_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b1;
      tick();
      chk("first_gid", 32'(grant_id), 32'h0);
      chk("first_busy", 32'(busy), 32'h1);

      // single requester
      do_reset();
      req_valid = 4'b0010;
      req_data  = 32'h0000_AA00;
      #1;
      chk("s_bubble_wr", 32'(fifo_wr), 32'h0);
      chk("s_bubble_busy", 32'(busy), 32'h0);
      tick();
      chk("s_b1_wr", 32'(fifo_wr), 32'h1);
      chk("s_b1_data", 32'(fifo_data), 32'hAA);
      chk("s_b1_gid", 32'(grant_id), 32'h1);
      chk("s_b1_ready", 32'(req_ready), 32'h2);
      tick();
      req_data = 32'h0000_5500;
      #1;
      chk("s_b2_wr", 32'(fifo_wr), 32'h1);
      chk("s_b2_data", 32'(fifo_data), 32'h55);
      tick();
      req_valid = 4'b0000;
      #1;
      chk("s_drop_wr", 32'(fifo_wr), 32'h0);
      chk("s_drop_busy", 32'(busy), 32'h1);
      tick();
      chk("s_rel_busy", 32'(busy), 32'h0);
      chk("s_rel_data", 32'(fifo_data), 32'h0);
      req_valid = 4'b0101;
      tick();
      chk("s_next_gid", 32'(grant_id), 32'h2);

      // full contention
      do_reset();
      req_valid = 4'b1111;
      req_data  = 32'hD3_C2_B1_A0;
      writes    = 0;
      idles     = 0;
      for (int c = 0; c < 25; c++) begin
         #1;
         if (fifo_wr) begin
            chk($sformatf("c_gid%0d", writes), 32'(grant_id),
                32'((writes / 4) % 4));
            chk($sformatf("c_dat%0d", writes), 32'(fifo_data),
                32'(8'hA0 + 8'h11 * 8'((writes / 4) % 4)));
            writes++;
         end
         if (!busy) idles++;
         tick();
      end
      chk("c_writes", 32'(writes), 32'd20);
      chk("c_idles", 32'(idles), 32'd5);

      // backpressure on requester 0
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h0000_00D0;
      tick();
      chk("bp_b1_wr", 32'(fifo_wr), 32'h1);
      tick();
      req_data = 32'h0000_00D1;
      #1;
      chk("bp_b2_data", 32'(fifo_data), 32'hD1);
      tick();
      req_data  = 32'h0000_00D2;
      fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp_full_wr%0d", c), 32'(fifo_wr), 32'h0);
         chk($sformatf("bp_full_rdy%0d", c), 32'(req_ready), 32'h0);
         chk($sformatf("bp_full_busy%0d", c), 32'(busy), 32'h1);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      chk("bp_b3_wr", 32'(fifo_wr), 32'h1);
      chk("bp_b3_data", 32'(fifo_data), 32'hD2);
      chk("bp_b3_rdy", 32'(req_ready), 32'h1);
      tick();
      req_data = 32'h0000_00D3;
      #1;
      chk("bp_b4_data", 32'(fifo_data), 32'hD3);
      chk("bp_b4_wr", 32'(fifo_wr), 32'h1);
      tick();
      chk("bp_done_busy", 32'(busy), 32'h0);
      chk("bp_done_wr", 32'(fifo_wr), 32'h0);

      // early release from requester 2 to 3
      do_reset();
      req_valid = 4'b1100;
      req_data  = 32'h33_22_00_00;
      tick();
      chk("er_gid2", 32'(grant_id), 32'h2);
      chk("er_wr", 32'(fifo_wr), 32'h1);
      tick();
      req_valid = 4'b1000;
      #1;
      chk("er_drop_wr", 32'(fifo_wr), 32'h0);
      chk("er_drop_rdy", 32'(req_ready), 32'h4);
      tick();
      chk("er_idle", 32'(busy), 32'h0);
      tick();
      chk("er_gid3", 32'(grant_id), 32'h3);
      chk("er_wr3", 32'(fifo_wr), 32'h1);

      // reset during beat 2 of requester 3's burst
      tick();
      rst = 1'b0;
      #1;
      chk("mr_b2_wr", 32'(fifo_wr), 32'h1);
      tick();
      chk("mr_busy", 32'(busy), 32'h0);
      chk("mr_wr", 32'(fifo_wr), 32'h0);
      chk("mr_gid", 32'(grant_id), 32'h0);
      rst       = 1'b1;
      req_valid = 4'b1001;
      tick();
      chk("mr_restart_gid", 32'(grant_id), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
